// File: rtl/dmem_port.sv
// dmem_port: word-organised data memory behind the pipeline's memory stage.
// One load or store at a time. Stores do a read-modify-write with per-lane byte
// enables. Loads return a word, or a byte/halfword with zero or sign extension.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// accesses are reported on resp_err and never write. When it is undefined, the
// offending low address bits are cleared and the access goes ahead.
module dmem_port #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_digit,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RSP  = 2'd3;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    logic [1:0]        state;
    logic              we_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd_q;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic [31:0]       new_data;
    logic [3:0]        mask;
    logic              accept;
    logic [1:0]        size_in;
    logic [1:0]        k_in;
    logic              unused_addr;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    assign req_ready   = (state == ST_IDLE);
    assign accept      = req_valid & req_ready;
    assign unused_addr = ^req_addr[31:ADDR_W+2];
    assign rd_word     = mem[idx_q];

    // Encoding 2'b11 behaves as a word access.
    assign size_in = (req_digit == 2'b11) ? SZ_WORD : req_digit;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_in;
    logic mis_q;
    logic err_q;
    assign mis_in   = ((size_in == SZ_HALF) && req_addr[0]) ||
                      ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign k_in     = req_addr[1:0];
    assign resp_err = err_q;
`else
    // Clear the low bits a misaligned access would otherwise use.
    assign k_in = (size_in == SZ_WORD) ? 2'b00 :
                  (size_in == SZ_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];
    assign resp_err = 1'b0;
`endif

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] k, input logic sgn);
        logic [31:0] s;
        s = w >> {k, 3'b000};
        case (size)
            SZ_HALF: extract = {{16{sgn & s[15]}}, s[15:0]};
            SZ_BYTE: extract = {{24{sgn & s[7]}}, s[7:0]};
            default: extract = w;
        endcase
    endfunction

    // Lane mask and byte merge of the new store data over the old word.
    always_comb begin
        mask     = 4'b1111;
        new_data = wdata_q;
        merged   = rd_q;
        case (size_q)
            SZ_HALF: begin
                mask     = 4'b0011 << k_q;
                new_data = {2{wdata_q[15:0]}};
            end
            SZ_BYTE: begin
                mask     = 4'b0001 << k_q;
                new_data = {4{wdata_q[7:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask[i] ? new_data[8*i +: 8] : rd_q[8*i +: 8];
        end
    end

    // RAM array: registered read in RD, merged write in WR (no reset on contents).
    always_ff @(posedge clk) begin
        if (state == ST_RD) begin
            rd_q <= rd_word;
        end
        if (state == ST_WR) begin
            mem[idx_q] <= merged;
        end
    end

    // Request capture, sequencing and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            sign_q     <= 1'b0;
            size_q     <= SZ_WORD;
            k_q        <= 2'b00;
            idx_q      <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        sign_q  <= req_sign;
                        size_q  <= size_in;
                        k_q     <= k_in;
                        idx_q   <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                        mis_q   <= mis_in;
`endif
                        state   <= ST_RD;
                    end
                end
                ST_RD: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                    err_q <= mis_q;
                    if (mis_q) begin
                        state      <= ST_RSP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                    end else
`endif
                    if (we_q) begin
                        state <= ST_WR;
                    end else begin
                        state      <= ST_RSP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extract(rd_word, size_q, k_q, sign_q);
                    end
                end
                ST_WR: begin
                    state      <= ST_RSP;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
